// File: rtl/prv664_axi_pkg.sv
// Shared AXI response encodings, severity merge and the queued write-response entry type.
`ifndef BUS_ID_W
`define BUS_ID_W 4
`endif

package prv664_axi_pkg;

    localparam int BUS_ID_W = `BUS_ID_W;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef struct packed {
        logic [BUS_ID_W-1:0] id;
        logic [1:0]          resp;
    } bresp_entry_t;

    // The encodings are numerically ordered by severity, so the worse one is the larger.
    function automatic logic [1:0] axi_resp_merge(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_bresp_gen_if.sv
// AXI write-response (B) channel; master drives the response, slave returns bready.
interface axi_b
    import prv664_axi_pkg::*;
#(
    parameter int ID_W = BUS_ID_W
);
    logic [ID_W-1:0] bid;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;

    // A response transfers on the cycle where bvalid && bready; bvalid, bid and bresp
    // hold steady from the cycle bvalid rises until that transfer, and bvalid never
    // waits on bready.
    modport master (output bid, output bresp, output bvalid, input bready);
    modport slave  (input bid, input bresp, input bvalid, output bready);
endinterface

// File: rtl/axi_bresp_fifo.sv
// Circular response queue; pointers carry one extra wrap bit to tell full from empty.
module axi_bresp_fifo
    import prv664_axi_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       srst_i,
    input  logic                       push_i,
    input  bresp_entry_t               push_data_i,
    input  logic                       pop_i,
    output bresp_entry_t               head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH)+1-1:0] count_o
);
    localparam int PTR_W = $clog2(DEPTH) + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    bresp_entry_t     mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr == rd_ptr);
    assign full_o  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                     (wr_ptr[PTR_W-2:0] == rd_ptr[PTR_W-2:0]);
    assign count_o = wr_ptr - rd_ptr;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem[rd_ptr[PTR_W-2:0]];

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // Storage needs no reset: an entry is only observed after it has been written.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr[PTR_W-2:0]] <= push_data_i;
    end
endmodule

// File: rtl/axi_bresp_gen.sv
// Folds per-beat error flags into one burst response and serves queued responses on B.
module axi_bresp_gen
    import prv664_axi_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ID_W  = BUS_ID_W
) (
    input  logic                       clk_i,
    input  logic                       srst_i,
    input  logic                       wbeat_valid_i,
    output logic                       wbeat_ready_o,
    input  logic [ID_W-1:0]            wbeat_id_i,
    input  logic                       wbeat_last_i,
    input  logic                       wbeat_slverr_i,
    input  logic                       wbeat_decerr_i,
    axi_b.master                       b,
    output logic [$clog2(DEPTH)+1-1:0] pending_o,
    output logic                       idle_o
);
    logic [1:0]   acc;
    logic         burst_active;
    logic [1:0]   beat_resp;
    logic [1:0]   merged;
    logic         beat_fire;
    logic         push;
    bresp_entry_t push_entry;
    bresp_entry_t head;
    logic         full;
    logic         empty;

    always_comb begin
        beat_resp = AXI_RESP_OKAY;
        if (wbeat_decerr_i)      beat_resp = AXI_RESP_DECERR;
        else if (wbeat_slverr_i) beat_resp = AXI_RESP_SLVERR;
    end

    assign merged          = axi_resp_merge(acc, beat_resp);
    assign wbeat_ready_o   = !full;
    assign beat_fire       = wbeat_valid_i && wbeat_ready_o;
    assign push            = beat_fire && wbeat_last_i;
    assign push_entry.id   = BUS_ID_W'(wbeat_id_i);
    assign push_entry.resp = merged;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            acc          <= AXI_RESP_OKAY;
            burst_active <= 1'b0;
        end else if (beat_fire) begin
            acc          <= wbeat_last_i ? AXI_RESP_OKAY : merged;
            burst_active <= !wbeat_last_i;
        end
    end

    axi_bresp_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i       (clk_i),
        .srst_i      (srst_i),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (b.bready),
        .head_o      (head),
        .full_o      (full),
        .empty_o     (empty),
        .count_o     (pending_o)
    );

    // Head fields are forced to zero while empty so the channel never shows stale data.
    assign b.bvalid = !empty;
    assign b.bid    = empty ? '0 : ID_W'(head.id);
    assign b.bresp  = empty ? AXI_RESP_OKAY : head.resp;
    assign idle_o   = empty && !burst_active;
endmodule

// File: tb/tb_axi_bresp_gen.sv
// Directed bench for axi_bresp_gen with a queue-level reference model checked every cycle.
module tb_axi_bresp_gen;
    import prv664_axi_pkg::*;

    localparam int DEPTH = 4;
    localparam int ID_W  = BUS_ID_W;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             srst_i = 1'b1;
    logic             wbeat_valid_i = 1'b0;
    logic             wbeat_ready_o;
    logic [ID_W-1:0]  wbeat_id_i = '0;
    logic             wbeat_last_i = 1'b0;
    logic             wbeat_slverr_i = 1'b0;
    logic             wbeat_decerr_i = 1'b0;
    logic [CNT_W-1:0] pending_o;
    logic             idle_o;

    int checks = 0;
    int errors = 0;

    axi_b #(.ID_W(ID_W)) b_if ();

    axi_bresp_gen #(.DEPTH(DEPTH), .ID_W(ID_W)) dut (
        .clk_i          (clk),
        .srst_i         (srst_i),
        .wbeat_valid_i  (wbeat_valid_i),
        .wbeat_ready_o  (wbeat_ready_o),
        .wbeat_id_i     (wbeat_id_i),
        .wbeat_last_i   (wbeat_last_i),
        .wbeat_slverr_i (wbeat_slverr_i),
        .wbeat_decerr_i (wbeat_decerr_i),
        .b              (b_if),
        .pending_o      (pending_o),
        .idle_o         (idle_o)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expected response queue {id, resp}, running worst response, burst flag.
    logic [ID_W+1:0] exp_q[$];
    logic [1:0]      m_acc = 2'b00;
    bit              m_burst = 1'b0;
    bit              model_live = 1'b0;

    always @(posedge clk) begin
        bit       can_pop;
        bit       can_take;
        logic [1:0] r;
        logic [1:0] worst;
        model_live = 1'b1;
        if (srst_i) begin
            exp_q.delete();
            m_acc   = 2'b00;
            m_burst = 1'b0;
        end else begin
            can_pop  = (exp_q.size() != 0) && b_if.bready;
            can_take = (exp_q.size() != DEPTH) && wbeat_valid_i;
            if (can_pop) void'(exp_q.pop_front());
            if (can_take) begin
                r     = wbeat_decerr_i ? 2'd3 : (wbeat_slverr_i ? 2'd2 : 2'd0);
                worst = (m_acc > r) ? m_acc : r;
                if (wbeat_last_i) begin
                    exp_q.push_back({wbeat_id_i, worst});
                    m_acc   = 2'b00;
                    m_burst = 1'b0;
                end else begin
                    m_acc   = worst;
                    m_burst = 1'b1;
                end
            end
        end
    end

    // Compare process: outputs sampled on the falling edge against the model.
    always @(negedge clk) begin
        if (model_live) begin
            check("bvalid", 32'(b_if.bvalid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                check("bid",   32'(b_if.bid),   32'(exp_q[0][ID_W+1:2]));
                check("bresp", 32'(b_if.bresp), 32'(exp_q[0][1:0]));
            end
            check("pending", 32'(pending_o), 32'(exp_q.size()));
            check("ready",   32'(wbeat_ready_o), 32'(exp_q.size() != DEPTH));
            check("idle",    32'(idle_o), 32'((exp_q.size() == 0) && !m_burst));
        end
    end

    // Driver: present one beat and hold it until the edge that accepts it.
    task automatic send_beat(input int id, input bit last, input bit slv, input bit dec);
        int n = 0;
        wbeat_valid_i  = 1'b1;
        wbeat_id_i     = ID_W'(id);
        wbeat_last_i   = last;
        wbeat_slverr_i = slv;
        wbeat_decerr_i = dec;
        while (!wbeat_ready_o && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!wbeat_ready_o) check("beat_accept_timeout", 32'(wbeat_ready_o), 32'd1);
        @(posedge clk); #1;
        wbeat_valid_i  = 1'b0;
        wbeat_last_i   = 1'b0;
        wbeat_slverr_i = 1'b0;
        wbeat_decerr_i = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n = 0;
        b_if.bready = 1'b1;
        while (!(idle_o && pending_o == 0) && n < 100) begin
            step();
            n++;
        end
        check("drain_idle", 32'(idle_o), 32'd1);
    endtask

    initial begin
        b_if.bready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        srst_i = 1'b0;
        check("rst_bvalid",  32'(b_if.bvalid), 32'd0);
        check("rst_bid",     32'(b_if.bid), 32'd0);
        check("rst_bresp",   32'(b_if.bresp), 32'd0);
        check("rst_ready",   32'(wbeat_ready_o), 32'd1);
        check("rst_pending", 32'(pending_o), 32'd0);
        check("rst_idle",    32'(idle_o), 32'd1);

        // Single-beat OKAY
        b_if.bready = 1'b1;
        send_beat(3, 1'b1, 1'b0, 1'b0);
        check("t1_bvalid",  32'(b_if.bvalid), 32'd1);
        check("t1_bid",     32'(b_if.bid), 32'd3);
        check("t1_bresp",   32'(b_if.bresp), 32'd0);
        check("t1_pending", 32'(pending_o), 32'd1);
        step();
        check("t1_bvalid_low", 32'(b_if.bvalid), 32'd0);
        check("t1_pending0",   32'(pending_o), 32'd0);

        // Burst error fold, then a clean burst shows the accumulator was cleared
        send_beat(5, 1'b0, 1'b0, 1'b0);
        check("t2_idle_mid", 32'(idle_o), 32'd0);
        send_beat(5, 1'b0, 1'b1, 1'b0);
        send_beat(5, 1'b0, 1'b0, 1'b1);
        send_beat(5, 1'b1, 1'b0, 1'b0);
        check("t2_bid",   32'(b_if.bid), 32'd5);
        check("t2_bresp", 32'(b_if.bresp), 32'd3);
        send_beat(6, 1'b0, 1'b0, 1'b0);
        send_beat(6, 1'b1, 1'b0, 1'b0);
        check("t2b_bid",   32'(b_if.bid), 32'd6);
        check("t2b_bresp", 32'(b_if.bresp), 32'd0);
        drain();

        // Backpressure until full, hold stable, then release in order
        b_if.bready = 1'b0;
        for (int i = 0; i < 4; i++) send_beat(i, 1'b1, 1'b0, 1'b0);
        check("t3_pending", 32'(pending_o), 32'd4);
        check("t3_ready",   32'(wbeat_ready_o), 32'd0);
        for (int i = 0; i < 10; i++) begin
            step();
            check("t3_hold_bid", 32'(b_if.bid), 32'd0);
        end
        b_if.bready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            step();
            check("t3_order", 32'(b_if.bid), 32'(i));
            if (i == 1) check("t3_ready_back", 32'(wbeat_ready_o), 32'd1);
        end
        drain();

        // Simultaneous push/pop at count 2, long enough to wrap the pointers
        b_if.bready = 1'b0;
        send_beat(7, 1'b1, 1'b0, 1'b0);
        send_beat(8, 1'b1, 1'b0, 1'b0);
        b_if.bready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            send_beat((9 + i) % 16, 1'b1, (i % 3) == 1, (i % 5) == 2);
            check("t4_pending", 32'(pending_o), 32'd2);
        end
        drain();

        // Reset mid-burst with responses queued
        b_if.bready = 1'b0;
        for (int i = 1; i < 4; i++) send_beat(i, 1'b1, 1'b0, 1'b0);
        send_beat(4, 1'b0, 1'b1, 1'b0);
        send_beat(4, 1'b0, 1'b1, 1'b0);
        srst_i = 1'b1;
        step();
        srst_i = 1'b0;
        check("t5_bvalid",  32'(b_if.bvalid), 32'd0);
        check("t5_pending", 32'(pending_o), 32'd0);
        check("t5_idle",    32'(idle_o), 32'd1);
        b_if.bready = 1'b1;
        send_beat(9, 1'b1, 1'b0, 1'b0);
        check("t5_bid",   32'(b_if.bid), 32'd9);
        check("t5_bresp", 32'(b_if.bresp), 32'd0);
        drain();

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
